// File: rtl/reg_op_sequencer.sv
// Round-robin sequencer sharing one control register among NREQ requesters.
// Each granted command expands into single-cycle clear/load/inc/dec/shift pulses.
module reg_op_sequencer #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int CNT_W = 3,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*3-1:0]      req_op,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  input  logic [NREQ*CNT_W-1:0]  req_cnt,
  input  logic [WIDTH-1:0]       reg_q,
  output logic                   r_cl,
  output logic                   r_ld,
  output logic                   r_inc,
  output logic                   r_dec,
  output logic                   r_sr,
  output logic                   r_sl,
  output logic                   r_ir,
  output logic                   r_il,
  output logic [WIDTH-1:0]       r_in,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [WIDTH-1:0]       result
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_q, rr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             gnt_vld;
  int               gnt;
  logic [2:0]       gop;
  logic [CNT_W-1:0] gcnt;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_vld && req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt     = j;
      end
    end
  end

  assign gop  = req_op[3*gnt +: 3];
  assign gcnt = req_cnt[CNT_W*gnt +: CNT_W];

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    req_ready = '0;
    r_cl      = 1'b0;
    r_ld      = 1'b0;
    r_inc     = 1'b0;
    r_dec     = 1'b0;
    r_sr      = 1'b0;
    r_sl      = 1'b0;
    r_ir      = 1'b0;
    r_il      = 1'b0;
    r_in      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          req_ready[gnt] = 1'b1;
          id_d   = IDW'(gnt);
          op_d   = gop;
          data_d = req_data[WIDTH*gnt +: WIDTH];
          cnt_d  = gcnt;
          rr_d   = (gnt == NREQ-1) ? '0 : IDW'(gnt + 1);
          // CLR and LOAD are always exactly one pulse.
          if (gop < 3'd2) begin
            cnt_d   = CNT_W'(1);
            state_d = S_EXEC;
          end else if (gcnt == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        unique case (op_q)
          3'd0: r_cl  = 1'b1;
          3'd1: begin
            r_ld = 1'b1;
            r_in = data_q;
          end
          3'd2: r_inc = 1'b1;
          3'd3: r_dec = 1'b1;
          3'd4: r_sr  = 1'b1;
          3'd5: r_sl  = 1'b1;
          3'd6: begin
            r_sr = 1'b1;
            r_ir = reg_q[0];
          end
          3'd7: begin
            r_sl = 1'b1;
            r_il = reg_q[WIDTH-1];
          end
          default: ;
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        res_d   = reg_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign done_id = id_q;
  // The register already holds the final value in DONE, so expose it immediately.
  assign result  = done ? reg_q : res_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Directed bench for reg_op_sequencer driving a behavioural 4-bit
// cl/ld/inc/dec/sr/sl register from the sequencer's control outputs.
module tb_reg_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [5:0] req_op;
  logic [7:0] req_data;
  logic [5:0] req_cnt;
  logic [3:0] rq;
  logic       r_cl, r_ld, r_inc, r_dec, r_sr, r_sl, r_ir, r_il;
  logic [3:0] r_in;
  logic       busy, done;
  logic [0:0] done_id;
  logic [3:0] result;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_op_sequencer #(.NREQ(2), .WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_cnt(req_cnt),
    .reg_q(rq),
    .r_cl(r_cl), .r_ld(r_ld), .r_inc(r_inc), .r_dec(r_dec),
    .r_sr(r_sr), .r_sl(r_sl), .r_ir(r_ir), .r_il(r_il),
    .r_in(r_in), .busy(busy), .done(done),
    .done_id(done_id), .result(result)
  );

  // Register instance the sequencer controls; not affected by rst.
  initial rq = 4'h0;
  always @(posedge clk) begin
    if (r_cl)       rq <= 4'h0;
    else if (r_ld)  rq <= r_in;
    else if (r_inc) rq <= rq + 4'd1;
    else if (r_dec) rq <= rq - 4'd1;
    else if (r_sr)  rq <= {r_ir, rq[3:1]};
    else if (r_sl)  rq <= {rq[2:0], r_il};
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input int op,
                         input int dat, input int cnt);
    req_op[3*id +: 3]   = 3'(op);
    req_data[4*id +: 4] = 4'(dat);
    req_cnt[3*id +: 3]  = 3'(cnt);
  endtask

  function automatic logic [5:0] strb_of(input int op);
    case (op)
      0:       return 6'b100000;
      1:       return 6'b010000;
      2:       return 6'b001000;
      3:       return 6'b000100;
      4, 6:    return 6'b000010;
      default: return 6'b000001;
    endcase
  endfunction

  task automatic do_cmd(input string tag, input int id, input int op,
                        input int dat, input int cnt, input int exp);
    int n;
    logic [1:0] eio;
    n = (op < 2) ? 1 : cnt;
    @(negedge clk);
    set_req(id, op, dat, cnt);
    req_valid = 2'(1 << id);
    #1 chk({tag, " ready"}, 32'(req_ready), 32'(1 << id));
    @(posedge clk);
    #1 req_valid = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      eio = (op == 6) ? {rq[0], 1'b0} :
            (op == 7) ? {1'b0, rq[3]} : 2'b00;
      chk({tag, " strobe"},
          32'({r_cl, r_ld, r_inc, r_dec, r_sr, r_sl}), 32'(strb_of(op)));
      chk({tag, " shin"}, 32'({r_ir, r_il}), 32'(eio));
      chk({tag, " r_in"}, 32'(r_in), (op == 1) ? 32'(dat) : 32'h0);
      chk({tag, " busy"}, 32'({busy, done}), 32'h2);
    end
    @(negedge clk);
    chk({tag, " done"}, 32'({done, busy}), 32'h3);
    chk({tag, " id"}, 32'(done_id), 32'(id));
    chk({tag, " result"}, 32'(result), 32'(exp));
    @(negedge clk);
    chk({tag, " held"}, 32'({done, busy, result}), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_op    = '0;
    req_data  = '0;
    req_cnt   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", 32'({busy, done, done_id, result, req_ready}), 32'h0);
    rst = 1'b0;

    do_cmd("load_a", 0, 1, 4'hA, 0, 4'hA);
    do_cmd("shr2",   0, 4, 0, 2, 4'h2);
    do_cmd("load_9", 1, 1, 4'h9, 0, 4'h9);
    do_cmd("rol1",   1, 7, 0, 1, 4'h3);
    do_cmd("load_f", 0, 1, 4'hF, 0, 4'hF);
    do_cmd("inc3",   0, 2, 0, 3, 4'h2);
    do_cmd("clr",    1, 0, 0, 5, 4'h0);
    do_cmd("load_5", 1, 1, 4'h5, 0, 4'h5);
    do_cmd("shl1",   0, 5, 0, 1, 4'hA);
    do_cmd("ror1a",  0, 6, 0, 1, 4'h5);
    do_cmd("ror1b",  1, 6, 0, 1, 4'hA);
    do_cmd("dec3",   1, 3, 0, 3, 4'h7);

    // Round robin: reset pointer, then both requesters stay valid.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 2, 0, 1);
    set_req(1, 2, 0, 1);
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1 chk("rr ready", 32'(req_ready), 32'(1 << (g % 2)));
      @(negedge clk);
      chk("rr pulse", 32'({r_inc, req_ready}), 32'h4);
      @(negedge clk);
      chk("rr done", 32'({done, req_ready}), 32'h4);
      chk("rr id", 32'(done_id), 32'(g % 2));
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("rr reg", 32'(rq), 32'hB);

    // Reset in the middle of a DEC x5.
    do_cmd("load_6", 0, 1, 4'h6, 0, 4'h6);
    @(negedge clk);
    set_req(0, 3, 0, 5);
    req_valid = 2'b01;
    #1 chk("abort ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk("abort dec1", 32'(r_dec), 32'h1);
    @(negedge clk);
    chk("abort dec2", 32'(r_dec), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort outs",
        32'({r_cl, r_ld, r_inc, r_dec, r_sr, r_sl, r_ir, r_il, r_in}),
        32'h0);
    chk("abort stat", 32'({busy, done, done_id, result}), 32'h0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy || r_dec) seen++;
    end
    chk("abort nodone", 32'(seen), 32'h0);
    chk("abort reg", 32'(rq), 32'h4);

    do_cmd("inc0", 0, 2, 0, 0, 4'h4);
    do_cmd("shr0", 1, 4, 0, 0, 4'h4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
